// File: rtl/decode_hazard_ctrl.sv
// rtl/decode_hazard_ctrl.sv - Decode-stage issue controller with register and MMU scoreboards
module decode_hazard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_MEM  = 2,
  parameter int R0_ZERO  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [ADDR_W-1:0]   dec_addr_a,
  input  logic [ADDR_W-1:0]   dec_addr_b,
  input  logic [ADDR_W-1:0]   dec_addr_d,
  input  logic                dec_use_a,
  input  logic                dec_use_b,
  input  logic                dec_write_d,
  input  logic                dec_is_mem,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                mem_done,
  output logic                issue,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [2:0]          mem_cnt,
  output logic [31:0]         stall_cycles,
  output logic                err
);

  localparam logic [2:0] MEM_LIMIT = 3'(MAX_MEM);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [2:0]          mem_cnt_q, mem_cnt_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;
  logic                err_q, err_d;
  logic                hazard;

  // Register 0 is hardwired when R0_ZERO is set, so it never participates in hazards or writes.
  function automatic logic is_r0(input logic [ADDR_W-1:0] adr);
    return (R0_ZERO != 0) && (adr == '0);
  endfunction

  // Hazard from current scoreboard state; no writeback bypass, so a clearing wb only helps next cycle.
  always_comb begin
    hazard = 1'b0;
    if (dec_use_a   && busy_q[dec_addr_a] && !is_r0(dec_addr_a)) hazard = 1'b1;
    if (dec_use_b   && busy_q[dec_addr_b] && !is_r0(dec_addr_b)) hazard = 1'b1;
    if (dec_write_d && busy_q[dec_addr_d] && !is_r0(dec_addr_d)) hazard = 1'b1;
    if (dec_is_mem  && (mem_cnt_q == MEM_LIMIT))                 hazard = 1'b1;
    issue = dec_valid & ~hazard;
    stall = dec_valid &  hazard;
  end

  // Next-state: scoreboard clear/set (set wins), MMU counter, stall counter, sticky error.
  always_comb begin
    busy_d         = busy_q;
    mem_cnt_d      = mem_cnt_q;
    stall_cycles_d = stall_cycles_q;
    err_d          = err_q;

    if (wb_valid && !is_r0(wb_addr)) begin
      if (busy_q[wb_addr]) busy_d[wb_addr] = 1'b0;
      else                 err_d = 1'b1;
    end

    if (issue && dec_write_d && !is_r0(dec_addr_d)) begin
      if (wb_valid && (wb_addr == dec_addr_d)) err_d = 1'b1;
      busy_d[dec_addr_d] = 1'b1;
    end

    if ((issue && dec_is_mem) && !mem_done) begin
      mem_cnt_d = mem_cnt_q + 3'd1;
    end else if (!(issue && dec_is_mem) && mem_done) begin
      if (mem_cnt_q == 3'd0) err_d = 1'b1;
      else                   mem_cnt_d = mem_cnt_q - 3'd1;
    end

    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q         <= '0;
      mem_cnt_q      <= 3'd0;
      stall_cycles_q <= 32'd0;
      err_q          <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      mem_cnt_q      <= mem_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      err_q          <= err_d;
    end
  end

  assign busy_vec     = busy_q;
  assign mem_cnt      = mem_cnt_q;
  assign stall_cycles = stall_cycles_q;
  assign err          = err_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb/tb_decode_hazard_ctrl.sv - self-checking bench for decode_hazard_ctrl
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_addr_a, dec_addr_b, dec_addr_d, wb_addr;
  logic        dec_use_a, dec_use_b, dec_write_d, dec_is_mem;
  logic        wb_valid, mem_done;
  logic        issue, stall, err;
  logic [31:0] busy_vec;
  logic [2:0]  mem_cnt;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.NUM_REGS(32), .ADDR_W(5), .MAX_MEM(2), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_addr_a(dec_addr_a), .dec_addr_b(dec_addr_b),
    .dec_addr_d(dec_addr_d), .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
    .dec_write_d(dec_write_d), .dec_is_mem(dec_is_mem),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .mem_done(mem_done),
    .issue(issue), .stall(stall), .busy_vec(busy_vec), .mem_cnt(mem_cnt),
    .stall_cycles(stall_cycles), .err(err)
  );

  typedef struct {
    bit          dv;
    int          a, b, d;
    bit          ua, ub, wd, mem, wbv;
    int          wba;
    bit          md;
    bit          ei, es;
    logic [31:0] ebusy;
    int          emem;
    bit          eerr;
    int          esc;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit dv, input int a, input int b, input int d,
                       input bit ua, input bit ub, input bit wd, input bit mem,
                       input bit wbv, input int wba, input bit md);
    dec_valid = dv; dec_addr_a = 5'(a); dec_addr_b = 5'(b); dec_addr_d = 5'(d);
    dec_use_a = ua; dec_use_b = ub; dec_write_d = wd; dec_is_mem = mem;
    wb_valid = wbv; wb_addr = 5'(wba); mem_done = md;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock with inputs applied just after the previous edge; settle to posedge+1.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reference model state, kept as plain arrays and integers.
  bit      m_busy[32];
  int      m_mem;
  bit      m_err;
  longint  m_sc;

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit m_hazard(input int a, input int b, input int d,
                                  input bit ua, input bit ub, input bit wd, input bit mem);
    bit h = 0;
    if (ua && a != 0 && m_busy[a]) h = 1;
    if (ub && b != 0 && m_busy[b]) h = 1;
    if (wd && d != 0 && m_busy[d]) h = 1;
    if (mem && m_mem == 2) h = 1;
    return h;
  endfunction

  initial begin
    reset = 1'b0;
    idle();

    //             dv a b d ua ub wd mem wbv wba md  ei es busy          mem err sc
    vecs[0]  = '{1, 3, 0, 5, 1, 0, 1, 0, 0, 0, 0,   1, 0, 32'h20, 0, 0, 0};
    vecs[1]  = '{1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 32'h20, 0, 0, 1};
    vecs[2]  = '{1, 0, 5, 0, 0, 1, 0, 0, 1, 5, 0,   0, 1, 32'h00, 0, 0, 2};
    vecs[3]  = '{1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0,   1, 0, 32'h00, 0, 0, 2};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 32'h00, 1, 0, 2};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 32'h00, 2, 0, 2};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 32'h00, 2, 0, 3};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,   0, 1, 32'h00, 1, 0, 4};
    vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 32'h00, 2, 0, 4};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 32'h00, 1, 0, 4};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,   1, 0, 32'h00, 1, 0, 4};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 32'h00, 1, 0, 4};
    vecs[12] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 32'h00, 1, 0, 4};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 32'h00, 0, 0, 4};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 32'h00, 0, 1, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_mem", 32'(mem_cnt), 32'd0);
    chk("rst_sc", stall_cycles, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table: issue/stall sampled mid-cycle, state after the edge.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].dv, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].ua, vecs[i].ub,
            vecs[i].wd, vecs[i].mem, vecs[i].wbv, vecs[i].wba, vecs[i].md);
      @(negedge clk);
      chk($sformatf("v%0d_issue", i), 32'(issue), 32'(vecs[i].ei));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].es));
      tick();
      chk($sformatf("v%0d_busy", i), busy_vec, vecs[i].ebusy);
      chk($sformatf("v%0d_mem", i), 32'(mem_cnt), 32'(vecs[i].emem));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].eerr));
      chk($sformatf("v%0d_sc", i), stall_cycles, 32'(vecs[i].esc));
    end

    // Spurious writeback to non-busy r7 raises err; r0 writeback does not.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    chk("wb_r0_err", 32'(err), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    @(negedge clk);
    chk("wb_r7_issue", 32'(issue), 32'd0);
    chk("wb_r7_stall", 32'(stall), 32'd0);
    tick();
    chk("wb_r7_err", 32'(err), 32'd1);
    chk("wb_r7_busy", busy_vec, 32'h0);

    // Asynchronous reset while stalled with busy[9] and two MMU accesses in flight.
    do_reset();
    drive(1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0); tick();
    drive(1, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    chk("pre_busy", busy_vec, 32'h200);
    chk("pre_mem", 32'(mem_cnt), 32'd2);
    chk("pre_err", 32'(err), 32'd1);
    chk("pre_stall", 32'(stall), 32'd1);
    chk("pre_sc", stall_cycles, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_mem", 32'(mem_cnt), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_sc", stall_cycles, 32'd0);
    chk("arst_issue", 32'(issue), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    idle();
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_mem = 0; m_err = 0; m_sc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit dv, ua, ub, wd, mem, wbv, md, h, iss, stl, inc;
      int a, b, d, wba;
      bit nb[32];
      dv  = ($urandom_range(0, 3) != 0);
      a   = $urandom_range(0, 7);
      b   = $urandom_range(0, 7);
      d   = $urandom_range(0, 7);
      ua  = $urandom_range(0, 1);
      ub  = $urandom_range(0, 1);
      wd  = $urandom_range(0, 1);
      mem = ($urandom_range(0, 2) == 0);
      wbv = ($urandom_range(0, 2) == 0);
      wba = $urandom_range(0, 7);
      md  = ($urandom_range(0, 4) == 0);
      drive(dv, a, b, d, ua, ub, wd, mem, wbv, wba, md);

      h   = m_hazard(a, b, d, ua, ub, wd, mem);
      iss = dv && !h;
      stl = dv && h;
      @(negedge clk);
      chk("rnd_issue", 32'(issue), 32'(iss));
      chk("rnd_stall", 32'(stall), 32'(stl));

      nb = m_busy;
      if (wbv && wba != 0) begin
        if (!m_busy[wba]) m_err = 1;
        else nb[wba] = 0;
      end
      if (iss && wd && d != 0) begin
        if (wbv && wba == d) m_err = 1;
        nb[d] = 1;
      end
      m_busy = nb;
      inc = iss && mem;
      if (inc && !md) m_mem = m_mem + 1;
      else if (!inc && md) begin
        if (m_mem == 0) m_err = 1;
        else m_mem = m_mem - 1;
      end
      if (stl && m_sc < 64'hFFFF_FFFF) m_sc = m_sc + 1;

      tick();
      chk("rnd_busy", busy_vec, m_busy_vec());
      chk("rnd_mem", 32'(mem_cnt), 32'(m_mem));
      chk("rnd_err", 32'(err), 32'(m_err));
      chk("rnd_sc", stall_cycles, m_sc[31:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
